// File: rtl/tap_serializer.sv
// Serializes a parallel tap vector one element per strobe, oldest (MSB slice) first.
// The strobe comes from a free-running counter, which also drives the heartbeat LED.
module tap_serializer #(
    parameter int COUNTER_WIDTH = 25,
    parameter int TOTAL_TAPS    = 9,
    parameter int BITS_PER_TAP  = 8,
    parameter int TOTAL_BITS    = 9 * 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [TOTAL_BITS-1:0]   i_taps,
    input  logic                    i_load_valid,
    output logic                    o_load_ready,
    output logic [BITS_PER_TAP-1:0] o_value,
    output logic                    o_value_valid,
    output logic                    o_last,
    output logic                    o_busy,
    output logic                    o_LED
);

    localparam int REM_W = $clog2(TOTAL_TAPS + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    if (TOTAL_BITS != TOTAL_TAPS * BITS_PER_TAP) begin : g_bad_width
        $error("TOTAL_BITS must equal TOTAL_TAPS*BITS_PER_TAP");
    end

    logic [COUNTER_WIDTH-1:0] cnt_q,   cnt_d;
    logic                     stb_q,   stb_d;
    logic [0:0]               state_q, state_d;
    logic [TOTAL_BITS-1:0]    shift_q, shift_d;
    logic [REM_W-1:0]         rem_q,   rem_d;
    logic [BITS_PER_TAP-1:0]  value_q, value_d;
    logic                     valid_q, valid_d;
    logic                     last_q,  last_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        cnt_d   = cnt_q + COUNTER_WIDTH'(1);
        stb_d   = (cnt_q == '0);
        state_d = state_q;
        shift_d = shift_q;
        rem_d   = rem_q;
        value_d = value_q;
        valid_d = 1'b0;
        last_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // A strobe coinciding with the load is deliberately not used for emission.
                if (i_load_valid) begin
                    shift_d = i_taps;
                    rem_d   = REM_W'(TOTAL_TAPS);
                    state_d = SEND;
                end
            end
            SEND: begin
                if (stb_q) begin
                    value_d = shift_q[TOTAL_BITS-1 -: BITS_PER_TAP];
                    shift_d = shift_q << BITS_PER_TAP;
                    rem_d   = rem_q - REM_W'(1);
                    valid_d = 1'b1;
                    if (rem_q == REM_W'(1)) begin
                        last_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all update together at the edge.
        if (!rst_n) begin
            cnt_q   <= '0;
            stb_q   <= 1'b0;
            state_q <= IDLE;
            shift_q <= '0;
            rem_q   <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stb_q   <= stb_d;
            state_q <= state_d;
            shift_q <= shift_d;
            rem_q   <= rem_d;
            value_q <= value_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign o_load_ready  = (state_q == IDLE);
    assign o_busy        = (state_q == SEND);
    assign o_value       = value_q;
    assign o_value_valid = valid_q;
    assign o_last        = last_q;
    assign o_LED         = ~cnt_q[COUNTER_WIDTH-1];

endmodule

// File: tb/tb_tap_serializer.sv
// Self-checking bench for tap_serializer: a queue-based reference model checked every
// cycle, a vector table with loopback rebuild, random vectors and directed corner cases.
module tb_tap_serializer;

    localparam int CW  = 2;
    localparam int TT  = 3;
    localparam int BPT = 8;
    localparam int TB  = TT * BPT;
    localparam int P   = 1 << CW;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [TB-1:0]  i_taps;
    logic           i_load_valid;
    logic           o_load_ready;
    logic [BPT-1:0] o_value;
    logic           o_value_valid;
    logic           o_last;
    logic           o_busy;
    logic           o_LED;

    tap_serializer #(
        .COUNTER_WIDTH(CW),
        .TOTAL_TAPS   (TT),
        .BITS_PER_TAP (BPT),
        .TOTAL_BITS   (TB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_taps       (i_taps),
        .i_load_valid (i_load_valid),
        .o_load_ready (o_load_ready),
        .o_value      (o_value),
        .o_value_valid(o_value_valid),
        .o_last       (o_last),
        .o_busy       (o_busy),
        .o_LED        (o_LED)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: edges since reset give the counter; emissions fall on edges n%P==2.
    logic [BPT-1:0] mq[$];
    int unsigned    mn = 0;
    logic           m_init = 1'b0;
    logic [BPT-1:0] m_value = '0;
    logic           m_valid = 1'b0;
    logic           m_last = 1'b0;

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            mn = 0; mq.delete(); m_value = '0; m_valid = 1'b0; m_last = 1'b0; m_init = 1'b1;
        end else if (m_init) begin
            mn++;
            m_valid = 1'b0;
            m_last  = 1'b0;
            if (mq.size() == 0) begin
                if (i_load_valid)
                    for (int k = TT - 1; k >= 0; k--) mq.push_back(i_taps[k*BPT +: BPT]);
            end else if ((mn % P) == 2) begin
                m_value = mq.pop_front();
                m_valid = 1'b1;
                m_last  = (mq.size() == 0);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_init) begin
            check("model_value", 32'(o_value), 32'(m_value));
            check("model_valid", 32'(o_value_valid), 32'(m_valid));
            check("model_last",  32'(o_last), 32'(m_last));
            check("model_ready", 32'(o_load_ready), 32'(mq.size() == 0));
            check("model_busy",  32'(o_busy), 32'(mq.size() != 0));
            check("model_led",   32'(o_LED), 32'((mn % P) < (P / 2)));
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 40; i++) begin
            if (o_load_ready) return;
            @(negedge clk);
        end
        check("ready_timeout", 32'(o_load_ready), 32'd1);
    endtask

    task automatic load(input logic [TB-1:0] t);
        wait_ready();
        i_taps       = t;
        i_load_valid = 1'b1;
        @(negedge clk);
        i_load_valid = 1'b0;
        i_taps       = TB'($urandom);
    endtask

    task automatic get_emit(output logic [BPT-1:0] v, output logic l, output int waited);
        v = '0; l = 1'b0; waited = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            waited++;
            if (o_value_valid) begin
                v = o_value;
                l = o_last;
                return;
            end
        end
        check("emit_timeout", 32'(o_value_valid), 32'd1);
    endtask

    // Collects one full vector, rebuilding it the way a downstream shift line would.
    task automatic collect(output logic [TB-1:0] rebuilt, output logic [TT-1:0] lasts,
                           output logic [BPT-1:0] first);
        logic [BPT-1:0] v;
        logic           l;
        int             w;
        rebuilt = '0; lasts = '0; first = '0;
        for (int e = 0; e < TT; e++) begin
            get_emit(v, l, w);
            if (e == 0) first = v;
            rebuilt = {rebuilt[TB-BPT-1:0], v};
            lasts   = {lasts[TT-2:0], l};
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [TB-1:0]  taps;
        logic [BPT-1:0] e0, e1, e2;
        int             gap;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TB-1:0]  rb, rb2;
        logic [TT-1:0]  ls;
        logic [BPT-1:0] fst, v;
        logic           l;
        int             w, toggles, bad_valid, bad_value;
        logic           prev_led;

        tbl[0] = '{24'hA1B2C3, 8'hA1, 8'hB2, 8'hC3, 0};
        tbl[1] = '{24'h112233, 8'h11, 8'h22, 8'h33, 3};
        tbl[2] = '{24'h000000, 8'h00, 8'h00, 8'h00, 1};
        tbl[3] = '{24'hFFFFFF, 8'hFF, 8'hFF, 8'hFF, 5};
        tbl[4] = '{24'h80017F, 8'h80, 8'h01, 8'h7F, 2};

        rst_n = 1'b0; i_taps = '0; i_load_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_value", 32'(o_value), 32'h0);
        check("rst_valid", 32'(o_value_valid), 32'h0);
        check("rst_last",  32'(o_last), 32'h0);
        check("rst_busy",  32'(o_busy), 32'h0);
        check("rst_ready", 32'(o_load_ready), 32'h1);
        rst_n = 1'b1;

        // Table vectors: per-element values, last flag, loopback rebuild, ready afterwards.
        foreach (tbl[i]) begin
            repeat (tbl[i].gap) @(negedge clk);
            load(tbl[i].taps);
            collect(rb, ls, fst);
            check("tbl_elem_oldest", 32'(rb[23:16]), 32'(tbl[i].e0));
            check("tbl_elem_mid",    32'(rb[15:8]),  32'(tbl[i].e1));
            check("tbl_elem_newest", 32'(rb[7:0]),   32'(tbl[i].e2));
            check("tbl_last_only_final", 32'(ls), 32'b001);
            check("tbl_loopback", 32'(rb), 32'(tbl[i].taps));
            check("tbl_ready_after", 32'(o_load_ready), 32'h1);
        end

        // Random vectors with random idle gaps.
        for (int r = 0; r < 20; r++) begin
            logic [TB-1:0] t;
            t = TB'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            load(t);
            collect(rb, ls, fst);
            check("rnd_loopback", 32'(rb), 32'(t));
            check("rnd_last", 32'(ls), 32'b001);
        end

        // Load on the same edge as a strobe: first element waits a full period.
        wait_ready();
        for (int i = 0; i < 8 && (mn % P) != 1; i++) @(negedge clk);
        load(24'hA1B2C3);
        get_emit(v, l, w);
        check("coincide_latency", 32'(w), 32'(P));
        check("coincide_first", 32'(v), 32'hA1);
        get_emit(v, l, w);
        get_emit(v, l, w);
        check("coincide_final", 32'(v), 32'hC3);

        // Load request held through SEND with different data is ignored until IDLE.
        wait_ready();
        i_taps = 24'hA1B2C3; i_load_valid = 1'b1;
        @(negedge clk);
        i_taps = 24'h112233;
        collect(rb, ls, fst);
        @(negedge clk);
        i_load_valid = 1'b0;
        check("held_busy_reload", 32'(o_busy), 32'h1);
        collect(rb2, ls, fst);
        check("held_first_vec", 32'(rb), 32'hA1B2C3);
        check("held_second_vec", 32'(rb2), 32'h112233);

        // Reset after the second element aborts the vector.
        load(24'hA1B2C3);
        get_emit(v, l, w);
        get_emit(v, l, w);
        check("abort_second", 32'(v), 32'hB2);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_value", 32'(o_value), 32'h0);
        check("abort_valid", 32'(o_value_valid), 32'h0);
        check("abort_last",  32'(o_last), 32'h0);
        check("abort_busy",  32'(o_busy), 32'h0);
        check("abort_ready", 32'(o_load_ready), 32'h1);
        rst_n = 1'b1;
        bad_valid = 0;
        repeat (12) begin
            @(negedge clk);
            if (o_value_valid) bad_valid++;
        end
        check("abort_no_emit", 32'(bad_valid), 32'h0);

        // Load on the first edge after reset release: first strobe arrives one cycle later.
        rst_n = 1'b0; i_taps = 24'h112233; i_load_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        i_load_valid = 1'b0;
        get_emit(v, l, w);
        check("post_reset_latency", 32'(w), 32'd1);
        check("post_reset_first", 32'(v), 32'h11);
        get_emit(v, l, w);
        get_emit(v, l, w);
        check("post_reset_last", 32'(l), 32'h1);

        // Idle heartbeat after reset: LED toggles every two clocks, no output activity.
        do_reset();
        prev_led = o_LED;
        toggles = 0; bad_valid = 0; bad_value = 0;
        repeat (16) begin
            @(negedge clk);
            if (o_LED != prev_led) toggles++;
            prev_led = o_LED;
            if (o_value_valid) bad_valid++;
            if (o_value != '0) bad_value++;
        end
        check("idle_led_toggles", 32'(toggles), 32'd8);
        check("idle_no_valid", 32'(bad_valid), 32'h0);
        check("idle_value_zero", 32'(bad_value), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tap_serializer.md
TAP_SERIALIZER -- requirements
Module: tap_serializer

Interface
REQ-001 Parameter COUNTER_WIDTH, default 25: width of the free-running strobe counter; one element is emitted per 2^COUNTER_WIDTH clocks.
REQ-002 Parameter TOTAL_TAPS, default 9: number of elements in one loaded tap vector.
REQ-003 Parameter BITS_PER_TAP, default 8: width of one element.
REQ-004 Parameter TOTAL_BITS, default 9*8: width of the tap vector; SHALL equal TOTAL_TAPS*BITS_PER_TAP.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 i_taps  input  TOTAL_BITS  parallel tap vector; element k is bits [k*BITS_PER_TAP +: BITS_PER_TAP]; element TOTAL_TAPS-1 (MSB slice) is the oldest.
REQ-008 i_load_valid  input  1  request to load i_taps.
REQ-009 o_load_ready  output  1  high when a load will be accepted.
REQ-010 o_value  output  BITS_PER_TAP  current serial element; holds between emissions.
REQ-011 o_value_valid  output  1  one-cycle pulse when o_value takes a new element.
REQ-012 o_last  output  1  high with o_value_valid on the final element of a vector; low otherwise.
REQ-013 o_busy  output  1  high while a vector is being emitted.
REQ-014 o_LED  output  1  heartbeat: inverse of counter MSB.

Function
REQ-015 Counter SHALL increment by 1 every clock, wrapping 2^COUNTER_WIDTH-1 -> 0, independent of FSM state.
REQ-016 Internal strobe stb SHALL be registered: high for exactly the one cycle following a cycle in which counter == 0.
REQ-017 FSM SHALL have two states: IDLE (o_load_ready=1, o_busy=0) and SEND (o_load_ready=0, o_busy=1).
REQ-018 Load handshake: i_load_valid && o_load_ready at a rising edge SHALL capture i_taps into the internal shift register, set remaining count to TOTAL_TAPS, and move to SEND.
REQ-019 In SEND, on each cycle with stb high: o_value <= MSB element of shift register, shift register shifts left by BITS_PER_TAP (zero fill), remaining decrements, o_value_valid pulses next cycle-aligned with the new o_value.
REQ-020 Emission order SHALL be oldest first (element TOTAL_TAPS-1 down to element 0), so a downstream shift_register_line clocked on the same strobe rebuilds the identical vector.
REQ-021 The emission that brings remaining to 0 SHALL assert o_last with o_value_valid and return the FSM to IDLE; o_load_ready rises the cycle o_value_valid/o_last is seen.
REQ-022 A stb coinciding with the load handshake in IDLE SHALL NOT emit; first element waits for the next stb.
REQ-023 i_load_valid while in SEND SHALL be ignored; no state or data change.
REQ-024 i_taps SHALL be sampled only at the accepting edge; later changes do not affect emitted data.
REQ-025 o_value SHALL hold its last value in IDLE and between strobes.
REQ-026 Remaining-count register SHALL be wide enough to hold TOTAL_TAPS (clog2(TOTAL_TAPS+1) bits).

Reset
REQ-027 With rst_n low at a rising edge: counter=0, stb=0, state=IDLE, shift register=0, remaining=0, o_value=0, o_value_valid=0, o_last=0, o_busy=0, o_load_ready=1.
REQ-028 Reset asserted mid-SEND SHALL abort the vector immediately; no further o_value_valid until a new load.
REQ-029 First stb after reset release SHALL occur on the second cycle after release (counter==0 on first, stb registered next).

Verification (COUNTER_WIDTH=2, TOTAL_TAPS=3, BITS_PER_TAP=8 unless stated)
REQ-030 Reset, then load i_taps=24'hA1B2C3 -> o_value_valid pulses 4 clocks apart carrying A1, B2, C3; o_last only with C3; o_load_ready high again afterwards.
REQ-031 Load asserted on the same edge as stb -> no emission that cycle; A1 appears on the following stb, 4 clocks later.
REQ-032 i_load_valid held high with new i_taps=24'h112233 during SEND -> ignored; A1,B2,C3 unchanged; new vector accepted only once back in IDLE, then 11,22,33.
REQ-033 rst_n low for one cycle after B2 emitted -> outputs return to reset values; C3 never emitted; o_load_ready=1.
REQ-034 Loopback: tap_serializer o_value into shift_register_line i_value, both COUNTER_WIDTH=2, reset together -> after 3 strobes o_taps equals loaded vector 24'hA1B2C3.
REQ-035 Idle run 16 clocks with no load -> o_LED toggles every 2 clocks, o_value_valid never asserts, o_value stays 0.
